axi4_wr_resp_track: RTL

- Single-clock stage directly downstream of the read side of the 6-bit write-response CDC FIFO, in the master clock domain.
- Pops {bid, bresp} words from the FIFO and presents them on the AXI4 B channel through a one-entry output register.
- Gates the AW channel so that the number of in-flight writes never exceeds a configured limit.
- Reports the outstanding count, idle status and protocol errors.

---
 rtl/axi4_wr_resp_track.sv | 124 ++++++++++++
 1 files changed

// File: rtl/axi4_wr_resp_track.sv
// Purpose: drains write responses from a FWFT CDC FIFO onto the AXI4 B channel and caps in-flight AW writes.
// Latency: FIFO non-empty to bvalid_o is 1 cycle; back-to-back responses at full rate while bready_i is high.
// Backpressure: bready_i low holds the B register and stops FIFO pops; AW is stalled when outstanding hits MAX_OUTSTANDING.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   aw_valid_i / aw_ready_o       upstream AW handshake (gated)
//   aw_valid_o / aw_ready_i       downstream AW handshake (gated)
//   fifo_data_i, fifo_empty_i     FWFT FIFO read side, data = {bid[3:0], bresp[1:0]}
//   fifo_pop_o                    FIFO pop, accepted in the same cycle
//   bvalid_o, bid_o, bresp_o      B channel output register
//   bready_i                      B channel ready
//   outstanding_o, idle_o         in-flight write count and idle status
//   err_unexpected_o, timeout_o   sticky error flags
//
// Optional macro AXI4_WR_RESP_TRACK_TIMEOUT_EN enables the response watchdog;
// without it timeout_o is tied low.

module axi4_wr_resp_track #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_W           = 5,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             aw_valid_i,
  output logic             aw_ready_o,
  output logic             aw_valid_o,
  input  logic             aw_ready_i,
  input  logic [5:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic             bvalid_o,
  output logic [3:0]       bid_o,
  output logic [1:0]       bresp_o,
  input  logic             bready_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             idle_o,
  output logic             err_unexpected_o,
  output logic             timeout_o
);

  logic [CNT_W-1:0] outstanding_q;
  logic             bvalid_q;
  logic [3:0]       bid_q;
  logic [1:0]       bresp_q;
  logic             err_q;
  logic             stall;
  logic             aw_fire;
  logic             b_fire;

  // Stall depends only on the registered count, so a B handshake at the
  // limit reopens AW one cycle later with no bready_i -> aw_ready_o path.
  assign stall      = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
  assign aw_valid_o = aw_valid_i & ~stall;
  assign aw_ready_o = aw_ready_i & ~stall;
  assign aw_fire    = aw_valid_o & aw_ready_i;
  assign b_fire     = bvalid_q & bready_i;

  // Pops are suppressed during reset so unread words survive in the FIFO.
  assign fifo_pop_o = ~rst_i & ~fifo_empty_i & (~bvalid_q | bready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      bid_q    <= 4'd0;
      bresp_q  <= 2'd0;
    end else if (fifo_pop_o) begin
      bvalid_q <= 1'b1;
      bid_q    <= fifo_data_i[5:2];
      bresp_q  <= fifo_data_i[1:0];
    end else if (bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      case ({aw_fire, b_fire})
        2'b10: outstanding_q <= outstanding_q + 1'b1;
        2'b01: begin
          // A response with nothing outstanding is flagged; count never wraps.
          if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
          else                     err_q         <= 1'b1;
        end
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

`ifdef AXI4_WR_RESP_TRACK_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wdog_q;
  logic            timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (b_fire || (outstanding_q == '0)) wdog_q <= '0;
      else if (wdog_q != TO_MAX)           wdog_q <= wdog_q + 1'b1;
      if (wdog_q == TO_MAX) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign bvalid_o         = bvalid_q;
  assign bid_o            = bid_q;
  assign bresp_o          = bresp_q;
  assign outstanding_o    = outstanding_q;
  assign idle_o           = (outstanding_q == '0) & ~bvalid_q;
  assign err_unexpected_o = err_q;

endmodule
